lcd_fill_engine: RTL and testbench

Pixel-stream generator on the LCD datapath: on a one-cycle `start` pulse from the colour sequencer, it sets a full-screen address window and streams `H_RES*V_RES` RGB565 pixels of one colour, then pulses `done`. This is the far end of the sequencer's `write_en` and `color_finish`/`clear_finish` handshake. It emits 9-bit command/data words to the downstream serial transmitter through a valid/ready interface.

---
 rtl/lcd_fill_pkg.sv | 30 +++
 rtl/lcd_setup_rom.sv | 32 +++
 rtl/lcd_fill_engine.sv | 161 ++++++++++++++++
 tb/tb_lcd_fill_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_fill_pkg.sv
// Shared constants, state encoding and word-packing helper for the LCD fill engine.
package lcd_fill_pkg;

  localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
  localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  localparam int   LCD_DC_BIT  = 8;
  localparam logic LCD_DC_CMD  = 1'b0;
  localparam logic LCD_DC_DATA = 1'b1;

  localparam int LCD_SETUP_LAST = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_FINISH
  } fill_state_e;

  function automatic logic [8:0] lcd_word(input logic dc, input logic [7:0] b);
    logic [8:0] w;
    w             = '0;
    w[LCD_DC_BIT] = dc;
    w[7:0]        = b;
    return w;
  endfunction

endpackage

// File: rtl/lcd_setup_rom.sv
// Combinational table of the 11-word address-window setup sequence (CASET, RASET, RAMWR).
module lcd_setup_rom
  import lcd_fill_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 240
) (
  input  logic [3:0] idx_i,
  output logic [8:0] word_o
);

  localparam logic [15:0] H_LAST = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST = 16'(V_RES - 1);

  always_comb begin
    // NOTE: default first so every path assigns word_o and no latch is inferred.
    word_o = '0;
    case (idx_i)
      4'd0:       word_o = lcd_word(LCD_DC_CMD, LCD_CMD_CASET);
      4'd1, 4'd2: word_o = lcd_word(LCD_DC_DATA, 8'h00);
      4'd3:       word_o = lcd_word(LCD_DC_DATA, H_LAST[15:8]);
      4'd4:       word_o = lcd_word(LCD_DC_DATA, H_LAST[7:0]);
      4'd5:       word_o = lcd_word(LCD_DC_CMD, LCD_CMD_RASET);
      4'd6, 4'd7: word_o = lcd_word(LCD_DC_DATA, 8'h00);
      4'd8:       word_o = lcd_word(LCD_DC_DATA, V_LAST[15:8]);
      4'd9:       word_o = lcd_word(LCD_DC_DATA, V_LAST[7:0]);
      4'd10:      word_o = lcd_word(LCD_DC_CMD, LCD_CMD_RAMWR);
      default:    word_o = '0;
    endcase
  end

endmodule

// File: rtl/lcd_fill_engine.sv
// Full-screen single-colour fill: address window setup then H_RES*V_RES RGB565 pixels.
// Optional frame border when LCD_FILL_BORDER_EN is defined.
module lcd_fill_engine
  import lcd_fill_pkg::*;
#(
  parameter int          H_RES       = 240,
  parameter int          V_RES       = 240,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
`ifdef LCD_FILL_BORDER_EN
  ,
  parameter logic [15:0] BORDER_COLOR = 16'hFFFF
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        clear,
  input  logic [15:0] color,
  output logic [8:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  fill_state_e   state_q;
  logic [15:0]   color_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [3:0]    setup_idx_q;
  logic [8:0]    tx_data_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic          done_q;
`ifdef LCD_FILL_BORDER_EN
  logic          clear_q;
`endif

  logic          fire;
  logic [3:0]    rom_idx;
  logic [8:0]    rom_word;
  logic          x_wrap;
  logic          last_pix;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic [15:0]   pix_cur;
  logic [15:0]   pix_nxt;

  assign fire     = tx_valid_q && tx_ready;
  // Registered data always holds the word on offer, so the ROM looks one entry ahead.
  assign rom_idx  = (state_q == ST_IDLE) ? 4'd0 : setup_idx_q + 4'd1;
  assign x_wrap   = (x_q == X_LAST);
  assign last_pix = x_wrap && (y_q == Y_LAST);
  assign x_nxt    = x_wrap ? '0 : x_q + XW'(1);
  assign y_nxt    = x_wrap ? y_q + YW'(1) : y_q;

  lcd_setup_rom #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_setup_rom (
    .idx_i  (rom_idx),
    .word_o (rom_word)
  );

`ifdef LCD_FILL_BORDER_EN
  function automatic logic [15:0] pixel_color(input logic [XW-1:0] x, input logic [YW-1:0] y);
    if (!clear_q && (x == '0 || x == X_LAST || y == '0 || y == Y_LAST)) return BORDER_COLOR;
    return color_q;
  endfunction

  assign pix_cur = pixel_color(x_q, y_q);
  assign pix_nxt = pixel_color(x_nxt, y_nxt);
`else
  assign pix_cur = color_q;
  assign pix_nxt = color_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      color_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      setup_idx_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LCD_FILL_BORDER_EN
      clear_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; done is a pulse that defaults low.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            color_q     <= clear ? CLEAR_COLOR : color;
`ifdef LCD_FILL_BORDER_EN
            clear_q     <= clear;
`endif
            setup_idx_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            tx_data_q   <= rom_word;
            tx_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (fire) begin
            if (setup_idx_q == 4'(LCD_SETUP_LAST)) begin
              tx_data_q <= lcd_word(LCD_DC_DATA, pix_cur[15:8]);
              state_q   <= ST_PIX_HI;
            end else begin
              setup_idx_q <= setup_idx_q + 4'd1;
              tx_data_q   <= rom_word;
            end
          end
        end
        ST_PIX_HI: begin
          if (fire) begin
            tx_data_q <= lcd_word(LCD_DC_DATA, pix_cur[7:0]);
            state_q   <= ST_PIX_LO;
          end
        end
        ST_PIX_LO: begin
          if (fire) begin
            if (last_pix) begin
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_FINISH;
            end else begin
              x_q       <= x_nxt;
              y_q       <= y_nxt;
              tx_data_q <= lcd_word(LCD_DC_DATA, pix_nxt[15:8]);
              state_q   <= ST_PIX_HI;
            end
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_fill_engine.sv
// Scoreboard bench for lcd_fill_engine: reference word stream per fill, decoupled monitor.
// Define LCD_FILL_BORDER_EN to exercise the border build on a 3x3 screen.
module tb_lcd_fill_engine;

`ifdef LCD_FILL_BORDER_EN
  localparam int H = 3;
  localparam int V = 3;
`else
  localparam int H = 4;
  localparam int V = 2;
`endif
  localparam logic [15:0] CLR_C  = 16'h0000;
  localparam logic [15:0] BRD_C  = 16'hFFFF;
  localparam int          BUDGET = 4000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] color = '0;
  logic        tx_ready = 1'b1;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  bit         rand_ready = 1'b0;
  logic [8:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_data = '0;

  lcd_fill_engine #(
    .H_RES       (H),
    .V_RES       (V),
    .CLEAR_COLOR (CLR_C)
`ifdef LCD_FILL_BORDER_EN
    ,
    .BORDER_COLOR(BRD_C)
`endif
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .clear    (clear),
    .color    (color),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference stream: window setup from the resolution, then row-major pixels.
  function automatic void push_fill(input logic clr, input logic [15:0] col);
    logic [15:0] hl;
    logic [15:0] vl;
    logic [15:0] c;
    hl = 16'(H - 1);
    vl = 16'(V - 1);
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, hl[15:8]});
    exp_q.push_back({1'b1, hl[7:0]});
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, vl[15:8]});
    exp_q.push_back({1'b1, vl[7:0]});
    exp_q.push_back(9'h02C);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        c = clr ? CLR_C : col;
`ifdef LCD_FILL_BORDER_EN
        if (!clr && (x == 0 || x == H - 1 || y == 0 || y == V - 1)) c = BRD_C;
`endif
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
    end
  endfunction

  // Monitor: pops on every transfer, checks hold-while-stalled and done timing.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %03h expected none (t=%0t)", tx_data, $time);
        end else begin
          check("word", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_drained", 32'(exp_q.size()), 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic run_fill(input logic clr, input logic [15:0] col, input int inject_at,
                          input int abort_at, input bit check_lat);
    int cyc;
    int d0;
    d0 = done_cnt;
    push_fill(clr, col);
    @(posedge clk); #1;
    start = 1'b1;
    clear = clr;
    color = col;
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'($urandom);
    color = 16'($urandom);
    cyc   = 1;
    check("busy_c1", 32'(busy), 32'd1);
    check("valid_c1", 32'(tx_valid), 32'd1);
    while (!done && cyc < BUDGET) begin
      if (cyc == abort_at) begin
        rstn = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        return;
      end
      start = (cyc == inject_at);
      if (start) begin
        clear = 1'b0;
        color = ~col;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", BUDGET);
      return;
    end
    if (check_lat) check("done_cycle", 32'(cyc), 32'(12 + 2 * H * V));
    start = 1'b1;
    color = ~col;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("start_at_done_ignored", 32'(tx_valid), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("stream_len", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    rstn = 1'b1;

    run_fill(1'b0, 16'hF800, -1, -1, 1'b1);
    run_fill(1'b0, 16'h001F, -1, -1, 1'b1);
    run_fill(1'b1, 16'h1234, -1, -1, 1'b1);
    rand_ready = 1'b1;
    run_fill(1'b0, 16'hF800, -1, -1, 1'b0);
    run_fill(1'b0, 16'h001F, -1, -1, 1'b0);
    rand_ready = 1'b0;
    run_fill(1'b0, 16'h07E0, 15, -1, 1'b1);
    run_fill(1'b0, 16'hABCD, -1, 20, 1'b0);
    run_fill(1'b0, 16'h5555, -1, -1, 1'b1);
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) run_fill(1'($urandom_range(0, 1)), 16'($urandom), -1, -1, 1'b0);
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
